hex_uart_rx: RTL and testbench
==============================

// Module: hex_uart_rx
// PURPOSE
//  UART receiver, 8N1, LSB first. Parses an ASCII hex word of 8 digits, most significant digit first,
//  terminated by a space (0x20), and returns it as a 32-bit word. This is the same stream the LCD/UART
//  transmitter emits, so a host can load words into the design.
//  Clocked in the CLK1 domain and placed beside the transmitter. Its output feeds control/test logic.
// PARAMETERS
//  BIT_WAIT  100  clocks per serial bit; must match the transmitter bit period, >=4
// PORTS
//  CLK    in   1   system clock; the only clock
//  RST    in   1   reset, synchronous, active-high
//  RXD    in   1   serial input, idle high, asynchronous to CLK
//  DATA   out  32  last accepted word; held until the next accept
//  VALID  out  1   one-cycle pulse when DATA updates
//  ERR    out  1   one-cycle pulse on a framing or parse error
// BEHAVIOUR
//  Reset: DATA=0, VALID=0, ERR=0, bit FSM=IDLE, digit count=0, accumulator=0, RXD sync flops=1.
//   RST mid-frame aborts the frame and discards partial digits.
//  RXD passes through a 2-FF synchronizer; all bit logic uses the synced value rxs.
//  Bit FSM (IDLE, START, DATA, STOP); waitcnt counts 0..BIT_WAIT-1:
//   IDLE: on rxs==0, go to START with waitcnt=0.
//   START: at waitcnt==BIT_WAIT/2-1, sample rxs. If 1: false start, go to IDLE, no ERR. If 0: go to DATA.
//   DATA: sample every BIT_WAIT clocks; bit i goes to shift[i]; after 8 bits, go to STOP.
//   STOP: sample after BIT_WAIT. If 1: byte done, go to IDLE. If 0: ERR pulse, discard partial word,
//    go to IDLE; a new start is only recognised after rxs returns to 1.
//  Parser acts on the byte-done cycle; its outputs are registered, so VALID/ERR appear the next clock:
//   '0'-'9', 'a'-'f', 'A'-'F': if cnt<8, acc <= {acc[27:0], nibble}, cnt++.
//     If cnt==8 (9th digit): ERR, set drop flag.
//   0x20 with cnt==8 and no drop: DATA<=acc, VALID pulse.
//   0x20 with cnt==0: ignored; leading or repeated spaces are legal.
//   0x20 with 0<cnt<8: ERR.
//   Any space: clear cnt, acc and drop.
//   Any other byte: ERR, set drop flag. Further digits are ignored until the next space.
//   ERR pulses once per offending event; while drop is set, no further ERR is raised until the space.
//  VALID and ERR are never high in the same cycle.
//  No back-pressure: a consumer that misses VALID loses only the pulse; DATA still holds the word.
//  Minimum spacing between VALID pulses is 9 byte times.
// CONFIGURATION
//  HEX_UART_RX_CRLF_EN
//   Defined: CR (0x0D) and LF (0x0A) act as terminators identical to 0x20.
//   Undefined: CR and LF are non-hex bytes and raise ERR with drop.
// STRUCTURE
//  hex_uart_rx_defs.vh holds:
//   ASCII constants: SP=8'h20, CR, LF, '0', 'a', 'A'.
//   Bit FSM state encodings (2 bits).
//   Digit count width (4 bits).
//  Sub-module uart_byte_rx: synchronizer + bit FSM.
//   Ports: CLK, RST, RXD -> BYTE[7:0], BDONE pulse, FERR pulse.
//   Parameter: BIT_WAIT.
//  hex_uart_rx: wraps uart_byte_rx and adds the hex parser, accumulator and output registers.
// TESTING (bench BIT_WAIT=16; the stimulus task drives 1 start, 8 data LSB-first, 1 stop)
//  1. "deadbeef " -> exactly one VALID; DATA=32'hdeadbeef; VALID rises one clock after the space's
//     stop sample; ERR stays 0.
//  2. Loopback: transmitter (same bit period) sends 32'h0123abcd into RXD -> DATA=32'h0123abcd, one VALID.
//  3. "  12AB34cD " -> leading spaces ignored; DATA=32'h12ab34cd.
//  4. "12g4 " -> one ERR at 'g'; no VALID; the following "00000001 " gives DATA=1.
//  5. "1234 " -> ERR at the space; DATA keeps its old value. "123456789 " -> ERR at '9'; no VALID.
//  6. Stop bit forced 0 -> ERR, byte lost. 3-clock low glitch on idle RXD -> no byte, no ERR.
//     RST asserted mid-byte -> all outputs 0, and the next full word decodes correctly.

Source files
------------

// File: rtl/hex_uart_rx_pkg.sv
// hex_uart_rx_pkg: shared constants, bit-FSM state type and the ASCII hex
// decode helpers used by the hex word receiver.
// Optional feature macro: HEX_UART_RX_CRLF_EN (CR/LF also terminate a word).
package hex_uart_rx_pkg;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_UA = 8'h41;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DIGITS = WORD_W / 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } bit_state_e;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } hex_dec_t;

  // Map one ASCII character to its hex nibble; ok=0 for non-hex bytes.
  function automatic hex_dec_t hex_decode(input logic [7:0] b);
    hex_dec_t r;
    r.ok  = 1'b0;
    r.nib = 4'd0;
    if (b >= ASCII_0 && b <= ASCII_0 + 8'd9) begin
      r.ok  = 1'b1;
      r.nib = 4'(b - ASCII_0);
    end else if (b >= ASCII_LA && b <= ASCII_LA + 8'd5) begin
      r.ok  = 1'b1;
      r.nib = 4'(b - ASCII_LA + 8'd10);
    end else if (b >= ASCII_UA && b <= ASCII_UA + 8'd5) begin
      r.ok  = 1'b1;
      r.nib = 4'(b - ASCII_UA + 8'd10);
    end
    return r;
  endfunction

  // Word terminator test.
  function automatic logic is_term(input logic [7:0] b);
`ifdef HEX_UART_RX_CRLF_EN
    return (b == ASCII_SP) || (b == ASCII_CR) || (b == ASCII_LF);
`else
    return (b == ASCII_SP);
`endif
  endfunction

endpackage

// File: rtl/hex_uart_rx_byte.sv
// hex_uart_rx_byte: 8N1 LSB-first byte receiver (2-FF synchronizer + bit FSM).
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   rxd_i    asynchronous serial input, idle high
//   byte_o   last assembled byte (valid while bdone_c is high)
//   bdone_c  combinational pulse on the stop-bit sample of a good frame
//   ferr_c   combinational pulse on the stop-bit sample of a framing error
module hex_uart_rx_byte
  import hex_uart_rx_pkg::*;
#(
  parameter int unsigned BIT_WAIT = 100
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       bdone_c,
  output logic       ferr_c
);

  localparam int unsigned WAIT_W = (BIT_WAIT > 1) ? $clog2(BIT_WAIT) : 1;
  localparam logic [WAIT_W-1:0] HALF_LAST = WAIT_W'(BIT_WAIT / 2 - 1);
  localparam logic [WAIT_W-1:0] BIT_LAST  = WAIT_W'(BIT_WAIT - 1);

  logic              meta_q, rxs_q;
  bit_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              hold_q, hold_d;

  // Synchronizer and FSM registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= ST_IDLE;
      wait_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      meta_q  <= rxd_i;
      rxs_q   <= meta_q;
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
    end
  end

  // Bit FSM: half-bit start check, then one sample per bit period.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    bdone_c = 1'b0;
    ferr_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        // After a bad stop bit the line must go high before a new start counts.
        if (hold_q) begin
          if (rxs_q) hold_d = 1'b0;
        end else if (!rxs_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (wait_q == HALF_LAST) begin
          wait_d  = '0;
          bit_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (wait_q == BIT_LAST) begin
          wait_d         = '0;
          shift_d[bit_q] = rxs_q;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (wait_q == BIT_LAST) begin
          wait_d  = '0;
          state_d = ST_IDLE;
          if (rxs_q) begin
            bdone_c = 1'b1;
          end else begin
            ferr_c = 1'b1;
            hold_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/hex_uart_rx.sv
// hex_uart_rx: receives an ASCII hex word (8 digits, MSD first, space
// terminated) over an 8N1 UART and presents it as a 32-bit word.
// Ports:
//   CLK    system clock
//   RST    synchronous active-high reset
//   RXD    serial input, idle high, asynchronous to CLK
//   DATA   last accepted word, held until the next accept
//   VALID  one-cycle pulse when DATA updates
//   ERR    one-cycle pulse on a framing or parse error
// Optional feature macro: HEX_UART_RX_CRLF_EN (CR/LF act like a space).
module hex_uart_rx
  import hex_uart_rx_pkg::*;
#(
  parameter int unsigned BIT_WAIT = 100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  output logic [WORD_W-1:0] DATA,
  output logic              VALID,
  output logic              ERR
);

  logic [7:0]        rx_byte;
  logic              bdone, ferr;
  hex_dec_t          dec;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  hex_uart_rx_byte #(
    .BIT_WAIT(BIT_WAIT)
  ) u_byte (
    .clk_i  (CLK),
    .rst_i  (RST),
    .rxd_i  (RXD),
    .byte_o (rx_byte),
    .bdone_c(bdone),
    .ferr_c (ferr)
  );

  // Parser and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Hex parser: one decision per received byte or framing error.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    dec     = hex_decode(rx_byte);
    if (ferr) begin
      // A broken frame loses the byte and whatever word was in progress.
      err_d  = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
      drop_d = 1'b0;
    end else if (bdone) begin
      if (is_term(rx_byte)) begin
        // A dropped word stays silent at its terminator; it already reported.
        if (!drop_q) begin
          if (cnt_q == CNT_W'(DIGITS)) begin
            data_d  = acc_q;
            valid_d = 1'b1;
          end else if (cnt_q != '0) begin
            err_d = 1'b1;
          end
        end
        acc_d  = '0;
        cnt_d  = '0;
        drop_d = 1'b0;
      end else if (!drop_q) begin
        if (dec.ok && cnt_q < CNT_W'(DIGITS)) begin
          acc_d = {acc_q[WORD_W-5:0], dec.nib};
          cnt_d = cnt_q + 1'b1;
        end else begin
          err_d  = 1'b1;
          drop_d = 1'b1;
        end
      end
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_hex_uart_rx.sv
// tb_hex_uart_rx: randomized and directed stimulus for hex_uart_rx, checked
// against a character-level reference model of the hex word protocol.
module tb_hex_uart_rx;

  localparam int unsigned BW = 16;
`ifdef HEX_UART_RX_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RXD = 1'b1;
  logic [31:0] DATA;
  logic        VALID;
  logic        ERR;

  hex_uart_rx #(.BIT_WAIT(BW)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .RXD  (RXD),
    .DATA (DATA),
    .VALID(VALID),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observation counters.
  int cyc = 0;
  int obs_valid = 0;
  int obs_err = 0;
  int obs_both = 0;
  int last_valid_cyc = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (VALID) begin
      obs_valid++;
      last_valid_cyc = cyc;
    end
    if (ERR) obs_err++;
    if (VALID && ERR) obs_both++;
  end

  // Reference model: digit string semantics of the hex word protocol.
  int          m_cnt = 0;
  logic [31:0] m_acc = 0;
  bit          m_drop = 0;
  logic [31:0] m_data = 0;
  int          m_valid = 0;
  int          m_err = 0;

  task automatic model_clear();
    m_cnt = 0; m_acc = 0; m_drop = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    int v;
    bit term;
    v = -1;
    if (b >= "0" && b <= "9") v = int'(b) - 48;
    else if (b >= "a" && b <= "f") v = int'(b) - 97 + 10;
    else if (b >= "A" && b <= "F") v = int'(b) - 65 + 10;
    term = (b == 8'h20) || (CRLF && (b == 8'h0D || b == 8'h0A));
    if (!stop_ok) begin
      m_err++;
      model_clear();
    end else if (term) begin
      if (!m_drop) begin
        if (m_cnt == 8) begin m_data = m_acc; m_valid++; end
        else if (m_cnt > 0) m_err++;
      end
      model_clear();
    end else if (!m_drop) begin
      if (v >= 0 && m_cnt < 8) begin
        m_acc = m_acc * 16 + 32'(v);
        m_cnt++;
      end else begin
        m_err++;
        m_drop = 1;
      end
    end
  endtask

  int frame_start_cyc;

  // One 8N1 frame, BW clocks per bit; a bad stop bit is followed by idle.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1 RXD = f[i];
      if (i == 0) frame_start_cyc = cyc;
      repeat (BW - 1) @(posedge CLK);
    end
    if (!stop_ok) begin
      @(posedge CLK);
      #1 RXD = 1'b1;
      repeat (2 * BW) @(posedge CLK);
    end
    model_byte(b, stop_ok);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
  endtask

  // Compare every accumulated observation with the model.
  task automatic end_test(input string tag);
    repeat (3 * BW) @(posedge CLK);
    check({tag, " valid count"}, 32'(obs_valid), 32'(m_valid));
    check({tag, " err count"}, 32'(obs_err), 32'(m_err));
    check({tag, " data"}, DATA, m_data);
    check({tag, " valid&err"}, 32'(obs_both), 32'd0);
  endtask

  initial begin
    byte q[$];
    logic [31:0] w;
    int n;
    int v;
    int bad_pos;
    logic [7:0] bad_set [4];
    bad_set[0] = "g"; bad_set[1] = "z"; bad_set[2] = "."; bad_set[3] = 8'hFF;

    // Reset
    RST = 1'b1; RXD = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("reset data", DATA, 32'd0);
    check("reset valid", 32'(VALID), 32'd0);
    check("reset err", 32'(ERR), 32'd0);
    RST = 1'b0;
    repeat (2 * BW) @(posedge CLK);

    // 1: basic word plus VALID timing after the space frame.
    send_str("deadbeef ");
    // sync(2) + start detect(1) + half bit + 8 data bits + 1 stop bit
    repeat (BW) @(posedge CLK);
    check("t1 valid latency", 32'(last_valid_cyc - frame_start_cyc), 32'(3 + BW / 2 + 9 * BW));
    check("t1 data literal", DATA, 32'hdeadbeef);
    end_test("t1");

    // 2: transmitter-style stream
    send_str($sformatf("%08h ", 32'h0123abcd));
    check("t2 data literal", DATA, 32'h0123abcd);
    end_test("t2");

    // 3: leading spaces, mixed case
    send_str("  12AB34cD ");
    check("t3 data literal", DATA, 32'h12ab34cd);
    end_test("t3");

    // 4: bad char then recovery
    send_str("12g4 ");
    end_test("t4a");
    send_str("00000001 ");
    check("t4 data literal", DATA, 32'h00000001);
    end_test("t4b");

    // 5: short word and overlong word
    send_str("1234 ");
    end_test("t5a");
    send_str("123456789 ");
    end_test("t5b");

    // 6a: framing error mid-word, then a good word
    send_str("ab");
    send_frame("5", 1'b0);
    send_str("cafef00d ");
    end_test("t6a");

    // 6b: short idle glitch must not produce a byte or error
    @(posedge CLK); #1 RXD = 1'b0;
    repeat (3) @(posedge CLK); #1 RXD = 1'b1;
    repeat (12 * BW) @(posedge CLK);
    end_test("t6b");

    // 6c: reset mid-byte
    send_str("1234");
    @(posedge CLK); #1 RXD = 1'b0;
    repeat (3 * BW) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("t6c rst data", DATA, 32'd0);
    check("t6c rst valid", 32'(VALID), 32'd0);
    check("t6c rst err", 32'(ERR), 32'd0);
    model_clear();
    m_data = 0;
    RXD = 1'b1;
    RST = 1'b0;
    repeat (2 * BW) @(posedge CLK);
    send_str("89abcdef ");
    check("t6c data literal", DATA, 32'h89abcdef);
    end_test("t6c");

    // Randomized words: random case, leading spaces, length and bad bytes.
    for (int it = 0; it < 14; it++) begin
      q.delete();
      w = $urandom;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 10) : 8;
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) q.push_back(8'h20);
      for (int d = 0; d < n; d++) begin
        v = int'((w >> (4 * ((7 - d) % 8))) & 32'hF);
        if (v < 10) q.push_back(8'(48 + v));
        else if ($urandom_range(0, 1) == 1) q.push_back(8'(65 + v - 10));
        else q.push_back(8'(97 + v - 10));
      end
      if ($urandom_range(0, 3) == 0) begin
        bad_pos = $urandom_range(0, q.size() - 1);
        q[bad_pos] = bad_set[$urandom_range(0, 3)];
      end
      q.push_back(8'h20);
      foreach (q[k]) send_frame(q[k], 1'b1);
      end_test($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
